// File: rtl/square_seq_pkg.sv
// Shared types and default sizing for the square-accumulator sequencer.
package square_seq_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int MAX_STEPS_DEF = 65535;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/square_seq_ctrl_if.sv
// Request / result bundle of the square-accumulator sequencer.
//
// Handshake: a start is taken only while busy_o is low, and n_i is sampled with it.
// The result transfers on the rising edge where res_valid_o and res_ready_i are both
// high. Once res_valid_o rises, res_o and count_o stay stable until that transfer.
// done_o marks the transfer cycle.
interface square_seq_ctrl_if #(
  parameter int WIDTH = square_seq_pkg::WIDTH_DEF
);
  logic                  start_i;
  logic [WIDTH-1:0]      n_i;
  logic                  pause_i;
  logic                  res_ready_i;
  logic                  busy_o;
  logic                  res_valid_o;
  logic [WIDTH-1:0]      res_o;
  logic [WIDTH-1:0]      count_o;
  logic                  done_o;
  logic                  err_o;
  square_seq_pkg::state_t state_o;   // debug view of the controller FSM

  modport slave (
    input  start_i, n_i, pause_i, res_ready_i,
    output busy_o, res_valid_o, res_o, count_o, done_o, err_o, state_o
  );

  modport master (
    output start_i, n_i, pause_i, res_ready_i,
    input  busy_o, res_valid_o, res_o, count_o, done_o, err_o, state_o
  );
endinterface

// File: rtl/square_seq_ctrl_odd_step_gen.sv
// Odd-step register: steps through 0, 2, 4, ... so that 1 + step is the next odd number.
module odd_step_gen #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] step
);

  // A clear wins over an advance, so a new run always starts from zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      step <= '0;
    else if (clr) step <= '0;
    else if (en)  step <= step + WIDTH'(2);
  end

endmodule

// File: rtl/square_seq_ctrl.sv
// Sequencer for the square accumulator. It runs n enabled steps so that acc == n*n,
// then offers the result on a valid/ready handshake. It checks the datapath
// invariants in-line and reports failures on a sticky error flag.
module square_seq_ctrl
  import square_seq_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  square_seq_ctrl_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_STEPS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, cnt_q, n_q;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] sq;
  logic             err_q;
  logic             clr, en, latch, reject, done, inv_fail;

  odd_step_gen #(.WIDTH(WIDTH)) u_step (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr),
    .en   (en),
    .step (step)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and datapath controls. Oversized requests leave the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    latch   = 1'b0;
    reject  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.n_i > MAX_N) begin
            reject = 1'b1;
          end else begin
            latch   = 1'b1;
            clr     = 1'b1;
            state_d = (bus.n_i == '0) ? RESULT : RUN;
          end
        end
      end
      RUN: begin
        if (!bus.pause_i) begin
          en = 1'b1;
          if (cnt_q + WIDTH'(1) == n_q) state_d = RESULT;
        end
      end
      RESULT: begin
        if (bus.res_ready_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, step counter and latched run length.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= '0;
      cnt_q <= '0;
      n_q   <= '0;
    end else begin
      if (latch) n_q <= bus.n_i;
      if (clr) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (en) begin
        acc_q <= acc_q + WIDTH'(1) + step;
        cnt_q <= cnt_q + WIDTH'(1);
      end
    end
  end

  // The invariants acc == count^2, step == 2*count and even step hold in every RUN
  // cycle, including paused ones.
  assign sq       = cnt_q * cnt_q;
  assign inv_fail = (state_q == RUN) &&
                    (step[0] || (acc_q != sq) || (step != {cnt_q[WIDTH-2:0], 1'b0}));

  // Sticky error flag. Only reset clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_q | reject | inv_fail;
  end

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.res_valid_o = (state_q == RESULT);
  assign bus.res_o       = acc_q;
  assign bus.count_o     = cnt_q;
  assign bus.done_o      = done;
  assign bus.err_o       = err_q;
  assign bus.state_o     = state_q;

endmodule
